// File: rtl/sayac_pkg.sv
// sayac_pkg: shared encodings for the SAYAC multi-mode counter.
//   cnt_mode_e  : terminal-count behaviour selected by the `mode` input
//   cnt_state_e : run/halt state of the counter (HALT only after a one-shot)
package sayac_pkg;

  typedef enum logic [1:0] {
    CNT_FREE    = 2'd0,
    CNT_MODULO  = 2'd1,
    CNT_ONESHOT = 2'd2,
    CNT_RELOAD  = 2'd3
  } cnt_mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/sayac_prescaler.sv
// sayac_prescaler: divides the count enable down to a tick.
//   clk, rst_n  : clock, async active-low reset
//   i_en        : count enable (level); pc advances only while high
//   i_clear     : synchronous clear of pc (driven by counter load)
//   i_prescale  : tick every i_prescale+1 enabled cycles
//   o_tick      : combinational tick, en && (pc == prescale)
module sayac_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic [PW-1:0] i_prescale,
  output logic          o_tick
);

  logic [PW-1:0] r_pc;

  assign o_tick = i_en && (r_pc == i_prescale);

  // A lowered prescale below the current pc lets pc run on and wrap
  // around before the next tick; no early restart is forced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_pc <= '0;
    else if (i_clear || o_tick) r_pc <= '0;
    else if (i_en)              r_pc <= r_pc + 1'b1;
  end

endmodule

// File: rtl/sayac_counter_mm.sv
// sayac_counter_mm: multi-mode up/down counter with limit, four
// terminal-count modes (free/modulo/one-shot/reload) and a prescaler.
//   clk, rst_n   : clock, async active-low reset
//   load         : sync load of initValue (beats a coincident tick)
//   initValue    : value loaded on load
//   en           : count enable, fed through the prescaler
//   dir          : 0 up, 1 down
//   mode         : cnt_mode_e
//   limit        : up terminal (non-FREE); down-wrap target in MODULO
//   reloadValue  : terminal reload value in RELOAD mode
//   prescale     : tick every prescale+1 enabled cycles
//   dataOut      : registered count
//   co           : registered one-cycle terminal event pulse
//   tc           : combinational "dataOut is at terminal"
//   done         : sticky one-shot completion flag
module sayac_counter_mm
  import sayac_pkg::*;
#(
  parameter int N  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [N-1:0]  initValue,
  input  logic          en,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  limit,
  input  logic [N-1:0]  reloadValue,
  input  logic [PW-1:0] prescale,
  output logic [N-1:0]  dataOut,
  output logic          co,
  output logic          tc,
  output logic          done
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  cnt_mode_e  w_mode;
  cnt_state_e r_state, w_state_nxt;
  logic       w_tick;
  logic       w_run;
  logic       w_step;
  logic [N-1:0] r_data;
  logic [N-1:0] w_data_nxt;
  logic         r_co;
  logic         r_done;

  assign w_mode = cnt_mode_e'(mode);

  sayac_prescaler #(.PW(PW)) u_presc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_clear    (load),
    .i_prescale (prescale),
    .o_tick     (w_tick)
  );

  // Up terminal uses >= so a value stranded above a newly lowered limit
  // still wraps on the next tick instead of running to all-ones.
  always_comb begin
    tc = 1'b0;
    if (dir)                    tc = (r_data == '0);
    else if (w_mode == CNT_FREE) tc = (r_data == ALL_ONES);
    else                        tc = (r_data >= limit);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (load)
      w_state_nxt = RUN;
    else if (r_state == RUN && w_tick && tc && w_mode == CNT_ONESHOT)
      w_state_nxt = HALT;
  end

  // FSM: outputs
  always_comb begin
    w_run  = (r_state == RUN);
    w_step = w_run && w_tick;
  end

  // Next count value for an accepted tick.
  always_comb begin
    w_data_nxt = r_data;
    if (!tc) begin
      w_data_nxt = dir ? r_data - 1'b1 : r_data + 1'b1;
    end else begin
      case (w_mode)
        CNT_FREE:    w_data_nxt = dir ? ALL_ONES : '0;
        CNT_MODULO:  w_data_nxt = dir ? limit    : '0;
        CNT_ONESHOT: w_data_nxt = r_data;
        CNT_RELOAD:  w_data_nxt = reloadValue;
        default:     w_data_nxt = r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_co   <= 1'b0;
      r_done <= 1'b0;
    end else if (load) begin
      r_data <= initValue;
      r_co   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_co <= w_step && tc;
      if (w_step) r_data <= w_data_nxt;
      if (w_step && tc && w_mode == CNT_ONESHOT) r_done <= 1'b1;
    end
  end

  assign dataOut = r_data;
  assign co      = r_co;
  assign done    = r_done;

endmodule

// File: tb/tb_sayac_counter_mm.sv
module tb_sayac_counter_mm;

  localparam int N  = 16;
  localparam int PW = 8;
  localparam logic [N-1:0] MAXV = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [N-1:0]  initValue;
  logic          en;
  logic          dir;
  logic [1:0]    mode;
  logic [N-1:0]  limit;
  logic [N-1:0]  reloadValue;
  logic [PW-1:0] prescale;
  logic [N-1:0]  dataOut;
  logic          co, tc, done;

  always #5 clk = ~clk;

  sayac_counter_mm #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .initValue(initValue), .en(en),
    .dir(dir), .mode(mode), .limit(limit), .reloadValue(reloadValue),
    .prescale(prescale), .dataOut(dataOut), .co(co), .tc(tc), .done(done)
  );

  // reference model state
  logic [N-1:0]  m_val;
  logic [PW-1:0] m_pc;
  bit            m_halt, m_co, m_done;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_term();
    if (dir)            return m_val == 0;
    else if (mode == 0) return m_val == MAXV;
    else                return m_val >= limit;
  endfunction

  task automatic m_reset();
    m_val = 0; m_pc = 0; m_halt = 0; m_co = 0; m_done = 0;
  endtask

  // One clock edge of the counter, from the rules in plain terms.
  task automatic m_edge();
    bit tick;
    if (load) begin
      m_val = initValue; m_pc = 0; m_done = 0; m_halt = 0; m_co = 0;
      return;
    end
    tick = en && (m_pc == prescale);
    if (tick)    m_pc = 0;
    else if (en) m_pc = m_pc + 1;
    m_co = 0;
    if (tick && !m_halt) begin
      if (!m_term()) begin
        m_val = dir ? m_val - 1 : m_val + 1;
      end else begin
        m_co = 1;
        case (mode)
          2'd0: m_val = dir ? MAXV : 16'd0;
          2'd1: m_val = dir ? limit : 16'd0;
          2'd2: begin m_done = 1; m_halt = 1; end
          default: m_val = reloadValue;
        endcase
      end
    end
  endtask

  task automatic cyc();
    m_edge();
    @(posedge clk); #1;
    chk("dataOut", dataOut, m_val);
    chk("co", co, m_co);
    chk("done", done, m_done);
    chk("tc", tc, m_term());
  endtask

  task automatic do_load(input logic [N-1:0] v);
    initValue = v; load = 1; cyc(); load = 0;
  endtask

  int nco;

  initial begin
    rst_n = 1; load = 0; initValue = 0; en = 0; dir = 0; mode = 0;
    limit = 0; reloadValue = 0; prescale = 0;
    #2 rst_n = 0;
    m_reset();
    #1;
    chk("rst_data", dataOut, 16'd0);
    chk("rst_co", co, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tc_free_up", tc, 1'b0);
    @(negedge clk); rst_n = 1;

    // MODULO up, limit 5
    mode = 1; dir = 0; limit = 5; prescale = 0; en = 1;
    do_load(0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("mod_seq", dataOut, i);
    end
    chk("mod_tc_at5", tc, 1'b1);
    cyc();
    chk("mod_wrap", dataOut, 16'd0);
    chk("mod_co", co, 1'b1);
    cyc();
    chk("mod_co_one", co, 1'b0);

    // ONESHOT down, prescale 2
    mode = 2; dir = 1; prescale = 2;
    do_load(3);
    nco = 0;
    repeat (14) begin cyc(); if (co) nco++; end
    chk("os_val", dataOut, 16'd0);
    chk("os_done", done, 1'b1);
    chk("os_co_cnt", nco, 1);
    repeat (6) cyc();
    chk("os_hold", dataOut, 16'd0);
    do_load(7);
    chk("os_reload_done", done, 1'b0);
    chk("os_reload_val", dataOut, 16'd7);
    repeat (4) cyc();
    chk("os_restart", dataOut, 16'd6);

    // RELOAD up 0xF0..0xFF
    mode = 3; dir = 0; limit = 16'h00FF; reloadValue = 16'h00F0; prescale = 0;
    do_load(16'h00F0);
    nco = 0;
    repeat (40) begin cyc(); if (co) nco++; end
    chk("rl_co_cnt", nco, 2);
    chk("rl_val", dataOut, 16'h00F8);

    // FREE down from 0
    mode = 0; dir = 1;
    do_load(0);
    cyc();
    chk("free_dn_val", dataOut, 16'hFFFF);
    chk("free_dn_co", co, 1'b1);

    // load beats tick at terminal; limit lowered under current value
    mode = 1; dir = 0; limit = 9;
    do_load(9);
    chk("lt_tc", tc, 1'b1);
    do_load(4);
    chk("lt_val", dataOut, 16'd4);
    chk("lt_co", co, 1'b0);
    do_load(9);
    limit = 2;
    cyc();
    chk("lim_drop_val", dataOut, 16'd0);
    chk("lim_drop_co", co, 1'b1);

    // limit 0 MODULO up: co every tick
    limit = 0;
    do_load(0);
    nco = 0;
    repeat (5) begin cyc(); if (co) nco++; end
    chk("lim0_co_cnt", nco, 5);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 29) == 0);
      initValue = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                              : 16'($urandom_range(0, 25));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        dir = 1'($urandom_range(0, 1));
        mode = 2'($urandom_range(0, 3));
        limit = 16'($urandom_range(0, 20));
        reloadValue = 16'($urandom_range(0, 20));
        prescale = 8'($urandom_range(0, 3));
      end
      cyc();
    end

    // async reset mid-count at 0x1234
    load = 0; mode = 0; dir = 0; prescale = 0; en = 1;
    do_load(16'h1230);
    repeat (4) cyc();
    chk("pre_rst_val", dataOut, 16'h1234);
    #1 rst_n = 0;
    m_reset();
    #1;
    chk("arst_data", dataOut, 16'd0);
    chk("arst_co", co, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk); rst_n = 1;
    cyc();
    chk("post_rst_count", dataOut, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sayac_counter_mm.md
# sayac_counter_mm

Parametrised multi-mode counter for SAYAC timers, loop counters and event counters. Extends the plain load/increment counter with up/down direction, a programmable limit, four terminal-count modes (free-run, modulo, one-shot, auto-reload) and a built-in prescaler. It sits beside the datapath/peripheral logic and is driven by controller strobes.

## Interface
- N, 16, counter width in bits
- PW, 8, prescaler width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  synchronous load strobe
- initValue  in  N  value loaded on `load`
- en  in  1  count enable (level)
- dir  in  1  0 = up, 1 = down
- mode  in  2  0 FREE, 1 MODULO, 2 ONESHOT, 3 RELOAD
- limit  in  N  up-count terminal for MODULO/ONESHOT/RELOAD; down-wrap target in MODULO
- reloadValue  in  N  value reloaded at terminal in RELOAD mode
- prescale  in  PW  tick every prescale+1 enabled cycles
- dataOut  out  N  counter value (registered)
- co  out  1  terminal event pulse (registered, one cycle)
- tc  out  1  dataOut is at terminal value (combinational)
- done  out  1  sticky one-shot completion flag (registered)

## Operation
- Priority per edge: rst_n > load > tick > hold.
- Internal prescaler count pc (PW bits): increments when en=1; tick = en && (pc == prescale); on tick or load pc <= 0; en=0 holds pc.
- Terminal value: dir=0 → limit (FREE: all-ones); dir=1 → 0. Up-count terminal test is dataOut >= limit, so values above limit (after mode/limit change) count as terminal.
- State machine: RUN, HALT. Reset → RUN. RUN→HALT on ONESHOT terminal tick. HALT→RUN only on load. In HALT ticks are ignored; dataOut holds.
- Tick in RUN, not at terminal: dataOut ± 1 (mod 2^N).
- Tick in RUN, at terminal, co <= 1 and:
  - FREE: up → 0, down → all-ones.
  - MODULO: up → 0, down → limit.
  - ONESHOT: hold, done <= 1, state → HALT.
  - RELOAD: dataOut <= reloadValue (either direction).
- load: dataOut <= initValue, pc <= 0, done <= 0, state → RUN, co <= 0; load beats a coincident tick.
- mode/dir/limit changes are sampled on each tick; no internal restart.
- limit = 0, MODULO up: counter stays 0, co pulses on every tick.

## Timing
- Reset values: dataOut = 0, co = 0, done = 0, pc = 0, state RUN; tc reflects dataOut = 0 immediately.
- Count latency: dataOut changes at the edge where tick is true; prescale = 0 gives one step per enabled cycle.
- co high for exactly the one cycle after the terminal-action edge; never high two consecutive cycles unless consecutive terminal ticks occur (limit=0 or RELOAD with reloadValue at terminal).
- done rises on the same edge as the ONESHOT co pulse; stays high until load or reset.
- rst_n assertion mid-count clears all state asynchronously; release is synchronised by the integrator.

## Structure
- Shared package sayac_pkg: mode encodings (CNT_FREE, CNT_MODULO, CNT_ONESHOT, CNT_RELOAD), state enum (RUN, HALT).
- One sub-module natural: sayac_prescaler (pc counter, outputs tick; inputs en, clear, prescale).
- Terminal compare and next-value mux in the top module.

## Test plan
- Reset: rst_n=0 mid-count at dataOut=0x1234 → dataOut=0, co=0, done=0 asynchronously.
- MODULO up, limit=5, prescale=0, en=1, load 0 → sequence 0..5,0; co high one cycle after 5→0 edge; tc high while dataOut=5.
- ONESHOT down, load 3, prescale=2 → decrements every 3 cycles 3,2,1,0, then holds; done=1 and one co pulse; further en ignored until load 7 restarts, done=0.
- RELOAD up, limit=0x00FF, reloadValue=0x00F0 → 0xF0..0xFF,0xF0 repeating; co per wrap; FREE down from 0 → 0xFFFF with co.
- load and tick same cycle at terminal → dataOut=initValue, co=0; change limit to 2 while dataOut=9 (up, MODULO) → next tick gives 0 with co.
